// File: rtl/rand_pos_ctrl.sv
// rand_pos_ctrl: draws up to MAX_NUM distinct, in-range grid cells from the shared random generator.
// Optional: define RAND_POS_EXCLUDE_EN to also reject cell (EXCL_X, EXCL_Y) as the ball spawn cell.
module rand_pos_ctrl #(
    parameter int MAX_NUM   = 7,
    parameter int X_LIMIT   = 16,
    parameter int Y_LIMIT   = 12,
    parameter int MAX_RETRY = 15,
    parameter int EXCL_X    = 0,
    parameter int EXCL_Y    = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [3:0]  i_num,
    input  logic [15:0] i_rand,
    output logic        o_rand_req,
    output logic        o_busy,
    output logic        o_pos_valid,
    output logic [3:0]  o_pos_idx,
    output logic [3:0]  o_pos_x,
    output logic [3:0]  o_pos_y,
    output logic        o_done,
    output logic        o_fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SAMPLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] NUM_CAP   = 4'(MAX_NUM);
    localparam logic [4:0] X_LIM     = 5'(X_LIMIT);
    localparam logic [4:0] Y_LIM     = 5'(Y_LIMIT);
    localparam logic [8:0] RETRY_LIM = 9'(MAX_RETRY);
    localparam logic [3:0] EX_X      = 4'(EXCL_X);
    localparam logic [3:0] EX_Y      = 4'(EXCL_Y);
`ifdef RAND_POS_EXCLUDE_EN
    localparam bit EXCL_EN = 1'b1;
`else
    localparam bit EXCL_EN = 1'b0;
`endif

    state_t      r_state;
    state_t      w_next;

    logic [3:0]  r_num;
    logic [3:0]  r_count;
    logic [7:0]  r_retry;
    logic [3:0]  r_cand_x;
    logic [3:0]  r_cand_y;
    logic [3:0]  r_mem_x [MAX_NUM];
    logic [3:0]  r_mem_y [MAX_NUM];

    logic        r_pos_valid;
    logic [3:0]  r_pos_idx;
    logic [3:0]  r_pos_x;
    logic [3:0]  r_pos_y;
    logic        r_done;
    logic        r_fail;

    logic [3:0]  w_n_start;
    logic        w_dup;
    logic        w_range_bad;
    logic        w_excl_hit;
    logic        w_reject;
    logic        w_last;
    logic        w_retry_out;
    logic        w_unused;

    // Only the low byte of the random word carries a cell.
    assign w_unused = &{1'b0, i_rand[15:8]};

    assign w_n_start = (i_num > NUM_CAP) ? NUM_CAP : i_num;

    // Candidate checks: range, reserved cell, and a parallel compare against every stored entry.
    assign w_range_bad = ({1'b0, r_cand_x} >= X_LIM) || ({1'b0, r_cand_y} >= Y_LIM);
    assign w_excl_hit  = EXCL_EN && (r_cand_x == EX_X) && (r_cand_y == EX_Y);

    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < MAX_NUM; i++) begin
            if ((4'(i) < r_count) && (r_mem_x[i] == r_cand_x) && (r_mem_y[i] == r_cand_y)) begin
                w_dup = 1'b1;
            end
        end
    end

    assign w_reject    = w_range_bad || w_dup || w_excl_hit;
    assign w_last      = ({1'b0, r_count} + 5'd1) == {1'b0, r_num};
    assign w_retry_out = ({1'b0, r_retry} + 9'd1) == RETRY_LIM;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next     = r_state;
        o_rand_req = 1'b0;
        o_busy     = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next = (w_n_start == 4'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                o_rand_req = 1'b1;
                w_next     = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_reject) begin
                    w_next = w_retry_out ? S_DONE : S_REQ;
                end else begin
                    w_next = w_last ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_num       <= '0;
            r_count     <= '0;
            r_retry     <= '0;
            r_cand_x    <= '0;
            r_cand_y    <= '0;
            r_pos_valid <= 1'b0;
            r_pos_idx   <= '0;
            r_pos_x     <= '0;
            r_pos_y     <= '0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            // NOTE: the position store is small and is cleared too, so no stale cell survives a reset.
            for (int i = 0; i < MAX_NUM; i++) begin
                r_mem_x[i] <= '0;
                r_mem_y[i] <= '0;
            end
        end else begin
            r_pos_valid <= 1'b0;
            // The end-of-run strobe trails the DONE state so it lands after the last position strobe.
            r_done      <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_num   <= w_n_start;
                        r_count <= '0;
                        r_retry <= '0;
                        r_fail  <= 1'b0;
                    end
                end
                S_SAMPLE: begin
                    r_cand_x <= i_rand[3:0];
                    r_cand_y <= i_rand[7:4];
                end
                S_CHECK: begin
                    if (w_reject) begin
                        if (r_retry != 8'hFF) begin
                            r_retry <= r_retry + 8'd1;
                        end
                        if (w_retry_out) begin
                            r_fail <= 1'b1;
                        end
                    end else begin
                        for (int i = 0; i < MAX_NUM; i++) begin
                            if (r_count == 4'(i)) begin
                                r_mem_x[i] <= r_cand_x;
                                r_mem_y[i] <= r_cand_y;
                            end
                        end
                        r_pos_valid <= 1'b1;
                        r_pos_idx   <= r_count;
                        r_pos_x     <= r_cand_x;
                        r_pos_y     <= r_cand_y;
                        r_retry     <= '0;
                        if (r_count != 4'hF) begin
                            r_count <= r_count + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_pos_valid = r_pos_valid;
    assign o_pos_idx   = r_pos_idx;
    assign o_pos_x     = r_pos_x;
    assign o_pos_y     = r_pos_y;
    assign o_done      = r_done;
    assign o_fail      = r_fail;

endmodule

// File: tb/tb_rand_pos_ctrl.sv
// Bench for rand_pos_ctrl: directed and random runs against a list-based model of the placement rules.
// Honours RAND_POS_EXCLUDE_EN the same way the design does.
module tb_rand_pos_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [3:0]  i_num;
    logic [15:0] i_rand;
    logic        o_rand_req;
    logic        o_busy;
    logic        o_pos_valid;
    logic [3:0]  o_pos_idx;
    logic [3:0]  o_pos_x;
    logic [3:0]  o_pos_y;
    logic        o_done;
    logic        o_fail;

    rand_pos_ctrl dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_num       (i_num),
        .i_rand      (i_rand),
        .o_rand_req  (o_rand_req),
        .o_busy      (o_busy),
        .o_pos_valid (o_pos_valid),
        .o_pos_idx   (o_pos_idx),
        .o_pos_x     (o_pos_x),
        .o_pos_y     (o_pos_y),
        .o_done      (o_done),
        .o_fail      (o_fail)
    );

    always #5 i_clk = ~i_clk;

`ifdef RAND_POS_EXCLUDE_EN
    localparam bit EXCL_ON = 1'b1;
`else
    localparam bit EXCL_ON = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fails  = 0;
    int unsigned q_words[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Word handed out for the k-th request; the last word repeats once the list runs out.
    function automatic int unsigned word_at(input int k);
        if (q_words.size() == 0) return 0;
        return (k < q_words.size()) ? q_words[k] : q_words[q_words.size() - 1];
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "_rand_req"}, int'(o_rand_req), 0);
        check({name, "_busy"},     int'(o_busy), 0);
        check({name, "_valid"},    int'(o_pos_valid), 0);
        check({name, "_idx"},      int'(o_pos_idx), 0);
        check({name, "_x"},        int'(o_pos_x), 0);
        check({name, "_y"},        int'(o_pos_y), 0);
        check({name, "_done"},     int'(o_done), 0);
        check({name, "_fail"},     int'(o_fail), 0);
    endtask

    // One complete run: model the expected outcome, then drive and score the DUT cycle by cycle.
    task automatic run(input string name, input int num, input bit poke);
        int          n, retry, reqs, t, got, done_t, seen_req, x, y;
        bit          fail_exp, bad;
        int          ex[$], ey[$], et[$];
        int unsigned w;

        n        = (num > 7) ? 7 : num;
        retry    = 0;
        reqs     = 0;
        fail_exp = 1'b0;
        while (ex.size() < n && !fail_exp) begin
            w    = word_at(reqs);
            reqs++;
            x    = int'(w & 32'hF);
            y    = int'((w >> 4) & 32'hF);
            bad  = (x >= 16) || (y >= 12) || (EXCL_ON && x == 0 && y == 0);
            foreach (ex[i]) if (ex[i] == x && ey[i] == y) bad = 1'b1;
            if (bad) begin
                retry++;
                if (retry == 15) fail_exp = 1'b1;
            end else begin
                ex.push_back(x);
                ey.push_back(y);
                et.push_back(3 * reqs + 1);
                retry = 0;
            end
        end

        @(negedge i_clk);
        i_num   = 4'(num);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start  = 1'b0;
        t        = 1;
        got      = 0;
        done_t   = -1;
        seen_req = 0;
        check({name, "_busy_t1"},  int'(o_busy), 1);
        check({name, "_fail_t1"},  int'(o_fail), 0);
        check({name, "_req_t1"},   int'(o_rand_req), (n > 0) ? 1 : 0);
        while (done_t < 0 && t < 3 * reqs + 20) begin
            if (o_rand_req) begin
                i_rand = 16'(word_at(seen_req));
                seen_req++;
            end
            if (o_pos_valid) begin
                if (got < ex.size()) begin
                    check({name, "_idx"},  int'(o_pos_idx), got);
                    check({name, "_x"},    int'(o_pos_x), ex[got]);
                    check({name, "_y"},    int'(o_pos_y), ey[got]);
                    check({name, "_time"}, t, et[got]);
                end else begin
                    check({name, "_extra_valid"}, got, ex.size());
                end
                got++;
            end
            if (o_done) begin
                done_t = t;
            end else begin
                if (poke) begin
                    i_start = (t == 4);
                    i_num   = 4'($urandom_range(0, 15));
                end
                @(negedge i_clk);
                t++;
            end
        end
        i_start = 1'b0;
        check({name, "_done_time"},   done_t, 3 * reqs + 2);
        check({name, "_req_count"},   seen_req, reqs);
        check({name, "_valid_count"}, got, ex.size());
        check({name, "_fail"},        int'(o_fail), int'(fail_exp));
        check({name, "_busy_done"},   int'(o_busy), 0);
        @(negedge i_clk);
        check({name, "_done_pulse"},  int'(o_done), 0);
        check({name, "_busy_after"},  int'(o_busy), 0);
        check({name, "_fail_held"},   int'(o_fail), int'(fail_exp));
        if (ex.size() > 0) begin
            check({name, "_x_held"}, int'(o_pos_x), ex[ex.size() - 1]);
            check({name, "_y_held"}, int'(o_pos_y), ey[ey.size() - 1]);
        end
    endtask

    initial begin
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_num   = '0;
        i_rand  = '0;
        repeat (3) @(negedge i_clk);
        check_all_zero("reset");
        i_rst = 1'b0;

        // Reset asserted while the first candidate is in CHECK aborts the run silently.
        @(negedge i_clk);
        i_num   = 4'd3;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("midrst_req", int'(o_rand_req), 1);
        i_rand = 16'h0021;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_all_zero("midrst");
        i_rst = 1'b0;
        repeat (4) begin
            @(negedge i_clk);
            check("midrst_no_done", int'(o_done), 0);
            check("midrst_idle",    int'(o_busy), 0);
        end

        q_words = {32'h0021, 32'h0053, 32'h00A7};
        run("basic", 3, 1'b0);

        q_words = {32'h0021, 32'h0021, 32'h00C4, 32'h0044};
        run("rejects", 2, 1'b0);

        q_words = {32'h0021};
        run("abort", 2, 1'b0);

        q_words = {32'h0033};
        run("after_abort", 1, 1'b0);

        q_words = {32'h0055};
        run("num_zero", 0, 1'b0);

        q_words.delete();
        for (int i = 0; i < 60; i++) q_words.push_back($urandom_range(0, 255));
        run("num_fifteen", 15, 1'b1);

        q_words = {32'h0000, 32'h0011};
        run("excl", 1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int num;
            q_words.delete();
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 3) == 0) q_words.push_back($urandom_range(0, 255));
                else q_words.push_back(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
            end
            num = int'($urandom_range(0, 15));
            run("random", num, num > 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
